// File: rtl/npi_port_arbiter.sv
// Two-client round-robin arbiter for a single MPMC NPI port; holds ownership until a read burst drains.
// Optional watchdog enabled by defining NPI_ARB_WATCHDOG_EN.
module npi_port_arbiter #(
    parameter int unsigned C_PI_ADDR_WIDTH = 32,
    parameter int unsigned C_PI_DATA_WIDTH = 64,
    parameter int unsigned C_PI_BE_WIDTH   = 8,
    parameter int unsigned C_TIMEOUT       = 1024
) (
    input  logic                       FSL_Clk,
    input  logic                       FSL_Rst,

    input  logic                       C0_Req,
    output logic                       C0_Gnt,
    output logic                       C0_Done,
    input  logic [C_PI_ADDR_WIDTH-1:0] C0_Addr,
    input  logic                       C0_AddrReq,
    input  logic                       C0_RNW,
    input  logic [3:0]                 C0_Size,
    input  logic [C_PI_DATA_WIDTH-1:0] C0_WrFIFO_Data,
    input  logic [C_PI_BE_WIDTH-1:0]   C0_WrFIFO_BE,
    input  logic                       C0_WrFIFO_Push,
    input  logic                       C0_RdFIFO_Pop,
    output logic [C_PI_DATA_WIDTH-1:0] C0_RdFIFO_Data,
    output logic                       C0_RdFIFO_Empty,

    input  logic                       C1_Req,
    output logic                       C1_Gnt,
    output logic                       C1_Done,
    input  logic [C_PI_ADDR_WIDTH-1:0] C1_Addr,
    input  logic                       C1_AddrReq,
    input  logic                       C1_RNW,
    input  logic [3:0]                 C1_Size,
    input  logic [C_PI_DATA_WIDTH-1:0] C1_WrFIFO_Data,
    input  logic [C_PI_BE_WIDTH-1:0]   C1_WrFIFO_BE,
    input  logic                       C1_WrFIFO_Push,
    input  logic                       C1_RdFIFO_Pop,
    output logic [C_PI_DATA_WIDTH-1:0] C1_RdFIFO_Data,
    output logic                       C1_RdFIFO_Empty,

    output logic [C_PI_ADDR_WIDTH-1:0] XIL_NPI_Addr,
    output logic                       XIL_NPI_AddrReq,
    input  logic                       XIL_NPI_AddrAck,
    output logic                       XIL_NPI_RNW,
    output logic [3:0]                 XIL_NPI_Size,
    output logic [C_PI_DATA_WIDTH-1:0] XIL_NPI_WrFIFO_Data,
    output logic [C_PI_BE_WIDTH-1:0]   XIL_NPI_WrFIFO_BE,
    output logic                       XIL_NPI_WrFIFO_Push,
    input  logic [C_PI_DATA_WIDTH-1:0] XIL_NPI_RdFIFO_Data,
    input  logic                       XIL_NPI_RdFIFO_Empty,
    output logic                       XIL_NPI_RdFIFO_Pop,
    input  logic                       XIL_NPI_InitDone,

    output logic                       Arb_Err
);

    localparam int unsigned SIZE_W = 4;
    localparam int unsigned BEAT_W = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RDRAIN  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t              state;
    logic                owner;
    logic                rr_ptr;
    logic [BEAT_W-1:0]   beat_cnt;
    logic                lat_rnw;
    logic [SIZE_W-1:0]   lat_size;

    logic                       owned;
    logic                       sel0;
    logic                       sel1;
    logic                       pick;
    logic                       own_req;
    logic [C_PI_ADDR_WIDTH-1:0] own_addr;
    logic                       own_addr_req;
    logic                       own_rnw;
    logic [SIZE_W-1:0]          own_size;
    logic [C_PI_DATA_WIDTH-1:0] own_wr_data;
    logic [C_PI_BE_WIDTH-1:0]   own_wr_be;
    logic                       own_wr_push;
    logic                       own_rd_pop;
    logic                       addr_hs;
    logic                       valid_pop;
    logic                       wd_expire;

    // 64-bit beats per NPI size code; unsupported codes count as a single beat.
    function automatic logic [BEAT_W-1:0] size_beats(input logic [SIZE_W-1:0] size);
        case (size)
            4'd0:    size_beats = 6'd1;
            4'd1:    size_beats = 6'd2;
            4'd2:    size_beats = 6'd4;
            4'd3:    size_beats = 6'd8;
            4'd4:    size_beats = 6'd16;
            4'd5:    size_beats = 6'd32;
            default: size_beats = 6'd1;
        endcase
    endfunction

    assign owned = (state == OWN) || (state == RDRAIN);
    assign sel0  = owned && !owner;
    assign sel1  = owned && owner;

    // Pointer only matters when both request; a lone requester always wins.
    assign pick = (C0_Req && C1_Req) ? rr_ptr : C1_Req;

    assign own_req      = owner ? C1_Req         : C0_Req;
    assign own_addr     = owner ? C1_Addr        : C0_Addr;
    assign own_addr_req = owner ? C1_AddrReq     : C0_AddrReq;
    assign own_rnw      = owner ? C1_RNW         : C0_RNW;
    assign own_size     = owner ? C1_Size        : C0_Size;
    assign own_wr_data  = owner ? C1_WrFIFO_Data : C0_WrFIFO_Data;
    assign own_wr_be    = owner ? C1_WrFIFO_BE   : C0_WrFIFO_BE;
    assign own_wr_push  = owner ? C1_WrFIFO_Push : C0_WrFIFO_Push;
    assign own_rd_pop   = owner ? C1_RdFIFO_Pop  : C0_RdFIFO_Pop;

    // During the drain the port shows the command already accepted, and no new address phase is allowed.
    assign XIL_NPI_Addr        = owned ? own_addr : '0;
    assign XIL_NPI_AddrReq     = (state == OWN) && own_addr_req;
    assign XIL_NPI_RNW         = (state == OWN) ? own_rnw  : ((state == RDRAIN) && lat_rnw);
    assign XIL_NPI_Size        = (state == OWN) ? own_size : ((state == RDRAIN) ? lat_size : '0);
    assign XIL_NPI_WrFIFO_Data = owned ? own_wr_data : '0;
    assign XIL_NPI_WrFIFO_BE   = owned ? own_wr_be   : '0;
    assign XIL_NPI_WrFIFO_Push = owned && own_wr_push;
    assign XIL_NPI_RdFIFO_Pop  = owned && own_rd_pop;

    assign C0_RdFIFO_Data  = sel0 ? XIL_NPI_RdFIFO_Data : '0;
    assign C1_RdFIFO_Data  = sel1 ? XIL_NPI_RdFIFO_Data : '0;
    assign C0_RdFIFO_Empty = owned && (sel0 ? XIL_NPI_RdFIFO_Empty : 1'b1);
    assign C1_RdFIFO_Empty = owned && (sel1 ? XIL_NPI_RdFIFO_Empty : 1'b1);

    assign addr_hs   = XIL_NPI_AddrReq && XIL_NPI_AddrAck;
    assign valid_pop = XIL_NPI_RdFIFO_Pop && !XIL_NPI_RdFIFO_Empty;

`ifdef NPI_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(C_TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;

    // Expires when an owned cycle without progress would make the count reach the limit.
    assign wd_expire = owned && !addr_hs && !valid_pop
                       && (wd_cnt == WD_W'(C_TIMEOUT - 1));

    always_ff @(posedge FSL_Clk or posedge FSL_Rst) begin
        if (FSL_Rst) begin
            wd_cnt  <= '0;
            Arb_Err <= 1'b0;
        end else begin
            if (!owned || addr_hs || valid_pop || wd_expire) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (wd_expire) begin
                Arb_Err <= 1'b1;
            end
        end
    end
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(C_TIMEOUT);
    assign wd_expire      = 1'b0;
    assign Arb_Err        = 1'b0;
`endif

    // Ownership FSM; grants and done pulses are registered.
    always_ff @(posedge FSL_Clk or posedge FSL_Rst) begin
        if (FSL_Rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            rr_ptr   <= 1'b0;
            beat_cnt <= '0;
            lat_rnw  <= 1'b0;
            lat_size <= '0;
            C0_Gnt   <= 1'b0;
            C1_Gnt   <= 1'b0;
            C0_Done  <= 1'b0;
            C1_Done  <= 1'b0;
        end else begin
            C0_Done <= 1'b0;
            C1_Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (XIL_NPI_InitDone && (C0_Req || C1_Req)) begin
                        owner  <= pick;
                        rr_ptr <= !pick;
                        C0_Gnt <= !pick;
                        C1_Gnt <= pick;
                        state  <= OWN;
                    end
                end
                OWN: begin
                    if (wd_expire) begin
                        C0_Gnt <= 1'b0;
                        C1_Gnt <= 1'b0;
                        state  <= IDLE;
                    end else if (addr_hs) begin
                        lat_rnw  <= own_rnw;
                        lat_size <= own_size;
                        if (own_rnw) begin
                            beat_cnt <= size_beats(own_size);
                            state    <= RDRAIN;
                        end else begin
                            C0_Done <= !owner;
                            C1_Done <= owner;
                            C0_Gnt  <= 1'b0;
                            C1_Gnt  <= 1'b0;
                            state   <= RELEASE;
                        end
                    end else if (!own_req) begin
                        C0_Gnt <= 1'b0;
                        C1_Gnt <= 1'b0;
                        state  <= RELEASE;
                    end
                end
                RDRAIN: begin
                    if (wd_expire) begin
                        C0_Gnt <= 1'b0;
                        C1_Gnt <= 1'b0;
                        state  <= IDLE;
                    end else if (valid_pop) begin
                        if (beat_cnt == BEAT_W'(1)) begin
                            C0_Done <= !owner;
                            C1_Done <= owner;
                            C0_Gnt  <= 1'b0;
                            C1_Gnt  <= 1'b0;
                            state   <= RELEASE;
                        end else begin
                            beat_cnt <= beat_cnt - BEAT_W'(1);
                        end
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
